// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types and defaults for the CAN transmit scheduler
package can_pkg;

  localparam int          CAN_PAYLOAD_W   = 64;
  localparam logic [31:0] CAN_TIMEOUT_DEF = 32'd200000;
  localparam logic [15:0] CAN_BACKOFF_DEF = 16'd64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_BACKOFF,
    S_REPORT
  } tx_state_e;

endpackage

// File: rtl/can_tx_scheduler_if.sv
// rtl/can_tx_scheduler_if.sv - mailbox, result and packet-layer signals of the scheduler
interface can_tx_scheduler_if #(
  parameter int NUM_MB = 4,
  parameter int IDX_W  = ($clog2(NUM_MB) < 1) ? 1 : $clog2(NUM_MB)
);
  logic                             wr_valid;
  logic [IDX_W-1:0]                 wr_idx;
  logic [can_pkg::CAN_PAYLOAD_W-1:0] wr_data;
  logic                             wr_ready;
  logic [NUM_MB-1:0]                abort;
  logic [NUM_MB-1:0]                pending;
  logic                             done_valid;
  logic [IDX_W-1:0]                 done_idx;
  logic                             done_ok;
  logic                             tx_start;
  logic [can_pkg::CAN_PAYLOAD_W-1:0] tx_data;
  logic                             tx_done;
  logic                             tx_acked;

  modport master (
    output wr_valid, wr_idx, wr_data, abort, tx_done, tx_acked,
    input  wr_ready, pending, done_valid, done_idx, done_ok, tx_start, tx_data
  );

  modport slave (
    input  wr_valid, wr_idx, wr_data, abort, tx_done, tx_acked,
    output wr_ready, pending, done_valid, done_idx, done_ok, tx_start, tx_data
  );
endinterface

// File: rtl/can_tx_scheduler_rr_pick.sv
// rtl/can_tx_scheduler_rr_pick.sv - first set request at or after ptr, searching with wrap
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    any = 1'b0;
    sum = '0;
    // descending scan so the smallest offset from ptr is the one kept
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (W+1)'(k);
        any = 1'b1;
      end
    end
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    idx = sum[W-1:0];
  end
endmodule

// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - round-robin mailbox scheduler in front of the CAN packet layer
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int          NUM_MB    = 4,
  parameter int          MAX_RETRY = 3,
  parameter logic [31:0] TIMEOUT   = CAN_TIMEOUT_DEF,
  parameter logic [15:0] BACKOFF   = CAN_BACKOFF_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  can_tx_scheduler_if.slave bus
);
  localparam int               IDX_W     = ($clog2(NUM_MB) < 1) ? 1 : $clog2(NUM_MB);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MB - 1);

  tx_state_e                state_q, state_d;
  logic [IDX_W-1:0]         cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [3:0]               retry_cnt_q, retry_cnt_d;
  logic [31:0]              tmo_cnt_q, tmo_cnt_d;
  logic [15:0]              bo_cnt_q, bo_cnt_d;
  logic                     abort_lat_q, abort_lat_d;
  logic [NUM_MB-1:0]        pending_q, pending_d;
  logic [CAN_PAYLOAD_W-1:0] mb_data_q [NUM_MB];
  logic [CAN_PAYLOAD_W-1:0] mb_data_d [NUM_MB];
  logic                     tx_start_q, tx_start_d;
  logic [CAN_PAYLOAD_W-1:0] tx_data_q, tx_data_d;
  logic                     done_valid_q, done_valid_d;
  logic [IDX_W-1:0]         done_idx_q, done_idx_d;
  logic                     done_ok_q, done_ok_d;

  logic              wr_ready, wr_fire, idx_ok;
  logic [NUM_MB-1:0] cur_mask, ab_mask;
  logic [IDX_W-1:0]  grant_idx, ab_idx;
  logic              grant_any, ab_any;
  logic              tmo_hit, bo_hit, abort_eff;
  logic              fin, fin_ok, ab_srv;

  rr_pick #(.N(NUM_MB), .W(IDX_W)) u_grant (
    .req (pending_q),
    .ptr (rr_ptr_q),
    .idx (grant_idx),
    .any (grant_any)
  );

  // aborts of mailboxes not on the wire are served lowest index first
  rr_pick #(.N(NUM_MB), .W(IDX_W)) u_abort (
    .req (ab_mask),
    .ptr ('0),
    .idx (ab_idx),
    .any (ab_any)
  );

  assign idx_ok    = {1'b0, bus.wr_idx} < (IDX_W+1)'(NUM_MB);
  assign wr_ready  = ~pending_q[bus.wr_idx];
  assign wr_fire   = bus.wr_valid & wr_ready & idx_ok;
  assign cur_mask  = (state_q != S_IDLE) ? (NUM_MB'(1) << cur_idx_q) : '0;
  assign ab_mask   = bus.abort & pending_q & ~cur_mask;
  assign tmo_hit   = ({1'b0, tmo_cnt_q} + 33'd1) >= {1'b0, TIMEOUT};
  assign bo_hit    = ({1'b0, bo_cnt_q} + 17'd1) >= {1'b0, BACKOFF};
  assign abort_eff = abort_lat_q | bus.abort[cur_idx_q];

  always_comb begin
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    rr_ptr_d     = rr_ptr_q;
    retry_cnt_d  = retry_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    bo_cnt_d     = bo_cnt_q;
    abort_lat_d  = abort_lat_q;
    pending_d    = pending_q;
    mb_data_d    = mb_data_q;
    tx_start_d   = tx_start_q;
    tx_data_d    = tx_data_q;
    done_valid_d = 1'b0;
    done_idx_d   = done_idx_q;
    done_ok_d    = done_ok_q;
    fin          = 1'b0;
    fin_ok       = 1'b0;
    ab_srv       = 1'b0;

    if (wr_fire) begin
      pending_d[bus.wr_idx] = 1'b1;
      mb_data_d[bus.wr_idx] = bus.wr_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (ab_any) begin
          ab_srv = 1'b1;
        end else if (grant_any) begin
          cur_idx_d   = grant_idx;
          tx_data_d   = mb_data_q[grant_idx];
          retry_cnt_d = '0;
          tmo_cnt_d   = '0;
          abort_lat_d = 1'b0;
          tx_start_d  = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 32'd1;
        if (bus.abort[cur_idx_q]) abort_lat_d = 1'b1;
        if (bus.tx_done && bus.tx_acked) begin
          fin    = 1'b1;
          fin_ok = 1'b1;
        end else if (bus.tx_done || tmo_hit) begin
          if (retry_cnt_q < RETRY_LIM && !abort_eff) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
            bo_cnt_d    = '0;
            tx_start_d  = 1'b0;
            state_d     = S_BACKOFF;
            ab_srv      = ab_any;
          end else begin
            fin = 1'b1;
          end
        end else begin
          ab_srv = ab_any;
        end
      end
      S_BACKOFF: begin
        bo_cnt_d = (bo_cnt_q == '1) ? bo_cnt_q : bo_cnt_q + 16'd1;
        if (bus.abort[cur_idx_q]) abort_lat_d = 1'b1;
        if (abort_eff) begin
          fin = 1'b1;
        end else begin
          if (bo_hit) begin
            tmo_cnt_d  = '0;
            tx_start_d = 1'b1;
            state_d    = S_SEND;
          end
          ab_srv = ab_any;
        end
      end
      S_REPORT: begin
        pending_d[cur_idx_q] = 1'b0;
        rr_ptr_d = (cur_idx_q == LAST_IDX) ? '0 : cur_idx_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // the in-flight result owns the done port; other aborts wait a cycle
    if (fin) begin
      state_d      = S_REPORT;
      tx_start_d   = 1'b0;
      done_valid_d = 1'b1;
      done_idx_d   = cur_idx_q;
      done_ok_d    = fin_ok;
    end else if (ab_srv) begin
      pending_d[ab_idx] = 1'b0;
      done_valid_d      = 1'b1;
      done_idx_d        = ab_idx;
      done_ok_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cur_idx_q    <= '0;
      rr_ptr_q     <= '0;
      retry_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      bo_cnt_q     <= '0;
      abort_lat_q  <= 1'b0;
      pending_q    <= '0;
      for (int i = 0; i < NUM_MB; i++) mb_data_q[i] <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      done_valid_q <= 1'b0;
      done_idx_q   <= '0;
      done_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      retry_cnt_q  <= retry_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      bo_cnt_q     <= bo_cnt_d;
      abort_lat_q  <= abort_lat_d;
      pending_q    <= pending_d;
      mb_data_q    <= mb_data_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      done_valid_q <= done_valid_d;
      done_idx_q   <= done_idx_d;
      done_ok_q    <= done_ok_d;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.pending    = pending_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_idx   = done_idx_q;
  assign bus.done_ok    = done_ok_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
endmodule
